// File: rtl/draw_msg_pkg.sv
// draw_msg_pkg: shared types and message tables for the end-of-game text
// overlay (draw_msg_text and msg_font_rom).
package draw_msg_pkg;

   typedef enum logic [1:0] {
      MSG_WIN   = 2'd0,
      MSG_LOSE  = 2'd1,
      MSG_TIE   = 2'd2,
      MSG_BLANK = 2'd3
   } msg_e;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      REVEAL = 2'd1,
      HOLD   = 2'd2
   } state_e;

   typedef enum logic [2:0] {
      GLYPH_W = 3'd0,
      GLYPH_I = 3'd1,
      GLYPH_N = 3'd2,
      GLYPH_L = 3'd3,
      GLYPH_O = 3'd4,
      GLYPH_S = 3'd5,
      GLYPH_E = 3'd6,
      GLYPH_T = 3'd7
   } glyph_e;

   // Message-to-glyph table, indexed [message][character]; character 0 is the
   // leftmost letter. Slots beyond a message's length are never displayed.
   localparam logic [3:0][3:0][2:0] MSG_TABLE = {
      {GLYPH_W, GLYPH_W, GLYPH_W, GLYPH_W},   // MSG_BLANK
      {GLYPH_W, GLYPH_E, GLYPH_I, GLYPH_T},   // MSG_TIE
      {GLYPH_E, GLYPH_S, GLYPH_O, GLYPH_L},   // MSG_LOSE
      {GLYPH_W, GLYPH_N, GLYPH_I, GLYPH_W}    // MSG_WIN
   };

   // Number of glyphs in each message.
   function automatic int msg_len(msg_e m);
      case (m)
         MSG_WIN:  return 3;
         MSG_LOSE: return 4;
         MSG_TIE:  return 3;
         default:  return 0;
      endcase
   endfunction

   // Glyph code for character idx of message m.
   function automatic glyph_e msg_glyph(msg_e m, logic [1:0] idx);
      return glyph_e'(MSG_TABLE[m][idx]);
   endfunction

endpackage

// File: rtl/msg_font_rom.sv
// msg_font_rom: combinational 8x8 glyph lookup. Returns one row of the
// selected glyph; bit 7 is the leftmost dot, row 0 the top row.
module msg_font_rom
   import draw_msg_pkg::*;
(
   input  glyph_e      glyph,
   input  logic [2:0]  row,
   output logic [7:0]  row_bits
);

   logic [0:7][7:0] rows;

   // Select the full bitmap of the requested glyph.
   always_comb begin
      // NOTE: default first so every path assigns rows and no latch is inferred.
      rows = '0;
      unique case (glyph)
         GLYPH_W: rows = 64'h8282_8292_92AA_4400;
         GLYPH_I: rows = 64'h7C10_1010_1010_7C00;
         GLYPH_N: rows = 64'h82C2_A292_8A86_8200;
         GLYPH_L: rows = 64'h8080_8080_8080_FE00;
         GLYPH_O: rows = 64'h7C82_8282_8282_7C00;
         GLYPH_S: rows = 64'h7C82_807C_0282_7C00;
         GLYPH_E: rows = 64'hFE80_80FC_8080_FE00;
         GLYPH_T: rows = 64'hFE10_1010_1010_1000;
      endcase
   end

   assign row_bits = rows[row];

endmodule

// File: rtl/draw_msg_text.sv
// draw_msg_text: animated end-of-game message overlay for the VGA screen.
// Reveals WIN / LOSE / TIE letter by letter on frame ticks and reports lit
// glyph dots through a fixed two-stage pixel pipeline.
// Optional macro DRAW_MSG_BLINK_EN: blink the fully shown message in HOLD.
module draw_msg_text
   import draw_msg_pkg::*;
#(
   parameter int SCALE         = 2,
   parameter int MAX_CHARS     = 4,
   parameter int REVEAL_FRAMES = 15,
   parameter int BLINK_FRAMES  = 30
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        frame_start,
   input  logic        show,
   input  logic [1:0]  msg_sel,
   input  logic [9:0]  Q_X,
   input  logic [9:0]  Q_Y,
   input  logic [9:0]  pos_x,
   input  logic [9:0]  pos_y,
   output logic        visible,
   output logic        busy,
   output logic        done
);

   localparam int SHIFT_S = $clog2(SCALE);
   localparam int SHIFT_C = SHIFT_S + 3;
   localparam int BOX_W   = MAX_CHARS * 8 * SCALE;
   localparam int BOX_H   = 8 * SCALE;
   localparam int CNT_W   = $clog2(MAX_CHARS + 1);
   localparam int FRAME_W = (REVEAL_FRAMES > 1) ? $clog2(REVEAL_FRAMES) : 1;

   if (SCALE != 1 && SCALE != 2 && SCALE != 4 && SCALE != 8) begin : g_bad_scale
      $error("draw_msg_text: SCALE must be 1, 2, 4 or 8");
   end
   if (REVEAL_FRAMES < 1) begin : g_bad_reveal
      $error("draw_msg_text: REVEAL_FRAMES must be at least 1");
   end
   if (BLINK_FRAMES < 1) begin : g_bad_blink
      $error("draw_msg_text: BLINK_FRAMES must be at least 1");
   end

   // Message length limited to what the character counter can show.
   function automatic logic [CNT_W-1:0] clamp_len(msg_e m);
      int n;
      n = msg_len(m);
      if (n > MAX_CHARS) n = MAX_CHARS;
      return CNT_W'(n);
   endfunction

   state_e             state;
   msg_e               msg_q;
   logic [CNT_W-1:0]   char_cnt;
   logic [FRAME_W-1:0] frame_cnt;
   logic [CNT_W-1:0]   len_q;
   logic [CNT_W-1:0]   sel_len;
   logic               blink_off;

   assign len_q   = clamp_len(msg_q);
   assign sel_len = clamp_len(msg_e'(msg_sel));

   // Reveal controller; every change waits for frame_start so a frame never tears.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments keep all state updates on the same edge.
      if (rst) begin
         state     <= IDLE;
         msg_q     <= MSG_WIN;
         char_cnt  <= '0;
         frame_cnt <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else if (frame_start) begin
         unique case (state)
            IDLE: begin
               if (show) begin
                  msg_q     <= msg_e'(msg_sel);
                  frame_cnt <= '0;
                  if (sel_len == '0) begin
                     state    <= HOLD;
                     char_cnt <= '0;
                     done     <= 1'b1;
                  end else begin
                     state    <= REVEAL;
                     char_cnt <= CNT_W'(1);
                     busy     <= 1'b1;
                  end
               end
            end
            REVEAL: begin
               if (!show) begin
                  state     <= IDLE;
                  char_cnt  <= '0;
                  frame_cnt <= '0;
                  busy      <= 1'b0;
                  done      <= 1'b0;
               end else if (frame_cnt == FRAME_W'(REVEAL_FRAMES - 1)) begin
                  frame_cnt <= '0;
                  if (char_cnt == len_q) begin
                     state <= HOLD;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end else begin
                     char_cnt <= char_cnt + 1'b1;
                  end
               end else begin
                  frame_cnt <= frame_cnt + 1'b1;
               end
            end
            HOLD: begin
               if (!show) begin
                  state     <= IDLE;
                  char_cnt  <= '0;
                  frame_cnt <= '0;
                  busy      <= 1'b0;
                  done      <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef DRAW_MSG_BLINK_EN
   localparam int BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   logic [BLINK_W-1:0] blink_cnt;
   logic               phase;

   // Blink timer: counts HOLD frames and flips the phase every BLINK_FRAMES.
   always_ff @(posedge clk) begin
      if (rst) begin
         blink_cnt <= '0;
         phase     <= 1'b0;
      end else if (state != HOLD || (frame_start && !show)) begin
         blink_cnt <= '0;
         phase     <= 1'b0;
      end else if (frame_start) begin
         if (blink_cnt == BLINK_W'(BLINK_FRAMES - 1)) begin
            blink_cnt <= '0;
            phase     <= ~phase;
         end else begin
            blink_cnt <= blink_cnt + 1'b1;
         end
      end
   end

   assign blink_off = phase;
`else
   assign blink_off = 1'b0;
`endif

   // Stage 1 geometry. The 11-bit difference keeps a box that runs off the
   // right or bottom edge clipped rather than wrapping to column/row 0.
   logic [10:0]      dx;
   logic [10:0]      dy;
   logic             in_zone;
   logic             in_zone_q;
   logic [CNT_W-1:0] char_idx_q;
   logic [2:0]       row_q;
   logic [2:0]       col_q;

   assign dx      = {1'b0, Q_X} - {1'b0, pos_x};
   assign dy      = {1'b0, Q_Y} - {1'b0, pos_y};
   assign in_zone = (Q_X >= pos_x) && (Q_Y >= pos_y) &&
                    (dx < 11'(BOX_W)) && (dy < 11'(BOX_H));

   // Stage 1: register box membership and the glyph cell coordinates.
   always_ff @(posedge clk) begin
      if (rst) begin
         in_zone_q  <= 1'b0;
         char_idx_q <= '0;
         row_q      <= '0;
         col_q      <= '0;
      end else begin
         in_zone_q  <= in_zone;
         char_idx_q <= CNT_W'(dx >> SHIFT_C);
         row_q      <= 3'(dy >> SHIFT_S);
         col_q      <= 3'(dx >> SHIFT_S);
      end
   end

   // Stage 2 glyph fetch for the registered character cell.
   glyph_e     glyph;
   logic [7:0] glyph_row;

   assign glyph = msg_glyph(msg_q, 2'(char_idx_q));

   msg_font_rom u_font (
      .glyph    (glyph),
      .row      (row_q),
      .row_bits (glyph_row)
   );

   // Stage 2: a dot is lit only for revealed characters of the latched message.
   always_ff @(posedge clk) begin
      if (rst) begin
         visible <= 1'b0;
      end else begin
         visible <= in_zone_q && (char_idx_q < char_cnt) && (char_idx_q < len_q) &&
                    glyph_row[3'd7 - col_q] && !blink_off;
      end
   end

endmodule

// File: tb/tb_draw_msg_text.sv
// tb_draw_msg_text: self-checking bench for draw_msg_text with a frame-level
// reference model (letters shown derived from frames since entry) and a
// two-cycle pixel scoreboard. Covers DRAW_MSG_BLINK_EN when it is defined.
module tb_draw_msg_text;

   localparam int SCALE         = 2;
   localparam int MAX_CHARS     = 4;
   localparam int REVEAL_FRAMES = 2;
   localparam int BLINK_FRAMES  = 3;
   localparam int GW            = 8 * SCALE;
   localparam int BOX_W         = MAX_CHARS * GW;

   logic       clk = 1'b0;
   logic       rst;
   logic       frame_start;
   logic       show;
   logic [1:0] msg_sel;
   logic [9:0] Q_X, Q_Y, pos_x, pos_y;
   logic       visible, busy, done;

   int checks = 0;
   int errors = 0;

   // Reference model: message active, which message, frames since entry.
   bit m_active;
   int m_msg;
   int m_k;

   // Pixel scoreboard: pixel driven now (cur) and one awaiting its result (pend).
   bit    cur_v, cur_e, pend_v, pend_e;
   int    cur_x, cur_y, pend_x, pend_y;
   string tag;

   always #5 clk = ~clk;

   draw_msg_text #(
      .SCALE         (SCALE),
      .MAX_CHARS     (MAX_CHARS),
      .REVEAL_FRAMES (REVEAL_FRAMES),
      .BLINK_FRAMES  (BLINK_FRAMES)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .frame_start (frame_start),
      .show        (show),
      .msg_sel     (msg_sel),
      .Q_X         (Q_X),
      .Q_Y         (Q_Y),
      .pos_x       (pos_x),
      .pos_y       (pos_y),
      .visible     (visible),
      .busy        (busy),
      .done        (done)
   );

   function automatic string msg_text(int m);
      case (m)
         0:       return "WIN";
         1:       return "LOSE";
         2:       return "TIE";
         default: return "";
      endcase
   endfunction

   function automatic logic [7:0] font_row(byte ch, int r);
      logic [7:0] g [8];
      case (ch)
         "W": g = '{8'h82, 8'h82, 8'h82, 8'h92, 8'h92, 8'hAA, 8'h44, 8'h00};
         "I": g = '{8'h7C, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h7C, 8'h00};
         "N": g = '{8'h82, 8'hC2, 8'hA2, 8'h92, 8'h8A, 8'h86, 8'h82, 8'h00};
         "L": g = '{8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'hFE, 8'h00};
         "O": g = '{8'h7C, 8'h82, 8'h82, 8'h82, 8'h82, 8'h82, 8'h7C, 8'h00};
         "S": g = '{8'h7C, 8'h82, 8'h80, 8'h7C, 8'h02, 8'h82, 8'h7C, 8'h00};
         "E": g = '{8'hFE, 8'h80, 8'h80, 8'hFC, 8'h80, 8'h80, 8'hFE, 8'h00};
         "T": g = '{8'hFE, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h00};
         default: g = '{default: 8'h00};
      endcase
      return g[r];
   endfunction

   function automatic int m_len();
      string s;
      s = msg_text(m_msg);
      return s.len();
   endfunction

   function automatic bit m_hold();
      return m_active && (m_k >= m_len() * REVEAL_FRAMES);
   endfunction

   function automatic bit m_busy();
      return m_active && !m_hold();
   endfunction

   function automatic int m_letters();
      int n;
      if (!m_active) return 0;
      n = 1 + m_k / REVEAL_FRAMES;
      if (n > m_len()) n = m_len();
      return n;
   endfunction

   function automatic bit m_blank();
`ifdef DRAW_MSG_BLINK_EN
      return m_hold() && ((((m_k - m_len() * REVEAL_FRAMES) / BLINK_FRAMES) % 2) == 1);
`else
      return 1'b0;
`endif
   endfunction

   function automatic bit model_vis(int x, int y);
      int px, py, dx, dy, ci;
      string s;
      logic [7:0] bits;
      px = int'(pos_x);
      py = int'(pos_y);
      if (!m_active || x < px || y < py) return 1'b0;
      dx = x - px;
      dy = y - py;
      if (dx >= BOX_W || dy >= GW) return 1'b0;
      ci = dx / GW;
      if (ci >= m_letters() || m_blank()) return 1'b0;
      s = msg_text(m_msg);
      bits = font_row(s[ci], dy / SCALE);
      return bits[7 - (dx / SCALE) % 8];
   endfunction

   // One clock; checks the pixel driven two edges ago against the model.
   task automatic tick();
      @(posedge clk);
      #1;
      if (pend_v) begin
         checks++;
         if (visible !== pend_e) begin
            errors++;
            $display("FAIL %s pixel(%0d,%0d): visible=%b expected=%b",
                     tag, pend_x, pend_y, visible, pend_e);
         end
      end
      pend_v = cur_v;
      pend_e = cur_e;
      pend_x = cur_x;
      pend_y = cur_y;
      cur_v  = 1'b0;
   endtask

   task automatic pix(input int x, input int y);
      Q_X   = 10'(x);
      Q_Y   = 10'(y);
      cur_v = 1'b1;
      cur_e = model_vis(x, y);
      cur_x = x;
      cur_y = y;
      tick();
   endtask

   task automatic frame(input bit s, input int ms);
      show        = s;
      msg_sel     = 2'(ms);
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      if (!m_active) begin
         if (s) begin
            m_active = 1'b1;
            m_msg    = ms;
            m_k      = 0;
         end
      end else if (!s) begin
         m_active = 1'b0;
      end else begin
         m_k++;
      end
   endtask

   task automatic sweep_box();
      int px, py;
      px = int'(pos_x);
      py = int'(pos_y);
      for (int y = py - 2; y < py + GW + 2; y++)
         for (int x = px - 2; x < px + BOX_W + 2; x++)
            if (x >= 0 && x < 1024 && y >= 0 && y < 1024) pix(x, y);
   endtask

   task automatic test_reset();
      tag = "reset";
      show = 1'b0; msg_sel = 2'd0; frame_start = 1'b0;
      pos_x = 10'd100; pos_y = 10'd50; Q_X = '0; Q_Y = '0;
      rst = 1'b1;
      repeat (3) tick();
      checks++;
      if (visible !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL reset outputs: visible=%b busy=%b done=%b expected 0 0 0",
                  visible, busy, done);
      end
      rst = 1'b0;
      m_active = 1'b0; m_msg = 0; m_k = 0;
      pix(100, 50);
      pix(101, 50);
      for (int f = 0; f < 4; f++) begin
         frame(1'b0, int'($urandom_range(0, 3)));
         checks++;
         if (busy !== m_busy() || done !== m_hold()) begin
            errors++;
            $display("FAIL reset idle frame %0d: busy=%b done=%b expected %b %b",
                     f, busy, done, m_busy(), m_hold());
         end
         for (int y = 0; y < 1024; y += 32) begin
            int off;
            off = int'($urandom_range(0, 31));
            for (int x = off; x < 1024; x += 32) pix(x, y);
         end
      end
   endtask

   task automatic test_win_reveal();
      tag = "win";
      pos_x = 10'd100; pos_y = 10'd50;
      frame(1'b1, 0);
      checks++;
      if (busy !== m_busy() || done !== m_hold()) begin
         errors++;
         $display("FAIL win entry: busy=%b done=%b expected %b %b", busy, done, m_busy(), m_hold());
      end
      // Isolated lit pixel between dark ones: result must appear two edges later.
      Q_X = 10'd0; Q_Y = 10'd0;
      tick(); tick();
      Q_X = 10'd100; Q_Y = 10'd50;
      tick();
      checks++;
      if (visible !== model_vis(0, 0)) begin
         errors++;
         $display("FAIL win lag1: visible=%b expected=%b", visible, model_vis(0, 0));
      end
      Q_X = 10'd0; Q_Y = 10'd0;
      tick();
      checks++;
      if (visible !== model_vis(100, 50)) begin
         errors++;
         $display("FAIL win lag2: visible=%b expected=%b", visible, model_vis(100, 50));
      end
      tick();
      checks++;
      if (visible !== model_vis(0, 0)) begin
         errors++;
         $display("FAIL win lag3: visible=%b expected=%b", visible, model_vis(0, 0));
      end
      pix(102, 50);
      for (int f = 1; f <= 7; f++) begin
         sweep_box();
         frame(1'b1, 0);
         checks++;
         if (busy !== m_busy() || done !== m_hold()) begin
            errors++;
            $display("FAIL win frame %0d: busy=%b done=%b expected %b %b",
                     f, busy, done, m_busy(), m_hold());
         end
      end
      sweep_box();
   endtask

   task automatic test_lose_box();
      tag = "lose";
      frame(1'b0, 0);
      frame(1'b1, 1);
      for (int f = 1; f <= 8; f++) begin
         frame(1'b1, 1);
         checks++;
         if (busy !== m_busy() || done !== m_hold()) begin
            errors++;
            $display("FAIL lose frame %0d: busy=%b done=%b expected %b %b",
                     f, busy, done, m_busy(), m_hold());
         end
      end
      for (int y = 48; y < 68; y++) begin
         pix(163, y);
         pix(164, y);
      end
      sweep_box();
   endtask

   task automatic test_drop_restart();
      tag = "drop";
      frame(1'b0, 0);
      frame(1'b1, 0);
      frame(1'b1, 0);
      frame(1'b1, 0);
      checks++;
      if (busy !== m_busy() || done !== m_hold()) begin
         errors++;
         $display("FAIL drop two chars: busy=%b done=%b expected %b %b", busy, done, m_busy(), m_hold());
      end
      sweep_box();
      frame(1'b0, 2);
      checks++;
      if (busy !== m_busy() || done !== m_hold()) begin
         errors++;
         $display("FAIL drop to idle: busy=%b done=%b expected %b %b", busy, done, m_busy(), m_hold());
      end
      sweep_box();
      frame(1'b1, 2);
      checks++;
      if (busy !== m_busy() || done !== m_hold()) begin
         errors++;
         $display("FAIL drop restart: busy=%b done=%b expected %b %b", busy, done, m_busy(), m_hold());
      end
      sweep_box();
      frame(1'b1, 3);
      frame(1'b1, 3);
      sweep_box();
      // Synchronous reset in the middle of the TIE reveal.
      tag = "rst_mid";
      tick();
      pend_v = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      m_active = 1'b0;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || visible !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid outputs: busy=%b done=%b visible=%b expected 0 0 0",
                  busy, done, visible);
      end
      for (int x = 100; x < 140; x++) pix(x, 50);
      frame(1'b1, 2);
      checks++;
      if (busy !== m_busy() || done !== m_hold()) begin
         errors++;
         $display("FAIL rst_mid restart: busy=%b done=%b expected %b %b", busy, done, m_busy(), m_hold());
      end
      sweep_box();
   endtask

   task automatic test_clip();
      tag = "clip";
      frame(1'b0, 0);
      pos_x = 10'd1010; pos_y = 10'd200;
      frame(1'b1, 0);
      checks++;
      if (busy !== m_busy() || done !== m_hold()) begin
         errors++;
         $display("FAIL clip entry: busy=%b done=%b expected %b %b", busy, done, m_busy(), m_hold());
      end
      for (int y = 198; y < 218; y++) begin
         for (int x = 1000; x < 1024; x++) pix(x, y);
         for (int x = 0; x < 16; x++) pix(x, y);
      end
   endtask

   task automatic test_hold();
      tag = "hold";
      frame(1'b0, 0);
      pos_x = 10'd300; pos_y = 10'd400;
      frame(1'b1, 1);
      for (int f = 1; f <= 8; f++) frame(1'b1, 1);
      for (int f = 0; f < 12; f++) begin
         checks++;
         if (busy !== m_busy() || done !== m_hold()) begin
            errors++;
            $display("FAIL hold frame %0d: busy=%b done=%b expected %b %b",
                     f, busy, done, m_busy(), m_hold());
         end
         for (int x = 298; x < 366; x++) pix(x, 400);
         frame(1'b1, 1);
      end
   endtask

   task automatic test_random();
      tag = "random";
      for (int it = 0; it < 30; it++) begin
         int px, py;
         pos_x = 10'($urandom_range(0, 1023));
         pos_y = 10'($urandom_range(0, 1023));
         frame($urandom_range(0, 4) != 0, int'($urandom_range(0, 3)));
         checks++;
         if (busy !== m_busy() || done !== m_hold()) begin
            errors++;
            $display("FAIL random frame %0d: busy=%b done=%b expected %b %b",
                     it, busy, done, m_busy(), m_hold());
         end
         px = int'(pos_x);
         py = int'(pos_y);
         for (int n = 0; n < 40; n++) begin
            int x, y;
            x = px - 4 + int'($urandom_range(0, BOX_W + 8));
            y = py - 4 + int'($urandom_range(0, GW + 8));
            if (x >= 0 && x < 1024 && y >= 0 && y < 1024) pix(x, y);
         end
      end
   endtask

   initial begin
      cur_v = 1'b0; pend_v = 1'b0;
      test_reset();
      test_win_reveal();
      test_lose_box();
      test_drop_restart();
      test_clip();
      test_hold();
      test_random();
      tick();
      tick();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation exceeded time budget");
      $fatal(1, "watchdog expired");
   end

endmodule
